// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Groups the controller's datapath-facing signals so the controller and the
//   datapath (or a bench) connect through one bundle.
//   slave  : controller side (receives start/opcode/flags/ack, drives controls)
//   master : datapath side (drives start/opcode/flags/ack, receives controls)
//   Signals:
//     start_i, Op_i[5:0], Zero_i, mem_ack_i           datapath -> controller
//     IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
//     RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o,
//     ALUSrcB_o[1:0], ALUOp_o[1:0], PCSrc_o[1:0],
//     PCWrite_o, illegal_o, state_o[3:0],
//     instr_cnt_o[31:0]                               controller -> datapath
interface multicycle_control_if;
    logic        start_i;
    logic [5:0]  Op_i;
    logic        Zero_i;
    logic        mem_ack_i;
    logic        IorD_o;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic        IRWrite_o;
    logic        RegDst_o;
    logic        MemtoReg_o;
    logic        RegWrite_o;
    logic        ALUSrcA_o;
    logic [1:0]  ALUSrcB_o;
    logic [1:0]  ALUOp_o;
    logic [1:0]  PCSrc_o;
    logic        PCWrite_o;
    logic        illegal_o;
    logic [3:0]  state_o;
    logic [31:0] instr_cnt_o;

    modport slave (
        input  start_i, Op_i, Zero_i, mem_ack_i,
        output IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o,
               RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSrc_o, PCWrite_o,
               illegal_o, state_o, instr_cnt_o
    );

    modport master (
        output start_i, Op_i, Zero_i, mem_ack_i,
        input  IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o,
               RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSrc_o, PCWrite_o,
               illegal_o, state_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequencing FSM for the multi-cycle MIPS datapath. Walks each instruction
//   through fetch/decode/execute/memory/write-back, stretches memory states
//   until mem_ack_i, and counts retired instructions.
//   Ports:
//     clk_i  : clock, all state on rising edge
//     rst_i  : synchronous active-high reset
//     bus    : multicycle_control_if.slave (opcode, flags, ack in; controls out)
//   Build option:
//     MC_ADDI_EN : when defined, addi (001000) is decoded through states 11/12;
//                  otherwise it is treated as an illegal opcode.
module multicycle_control (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t      state_q, state_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    logic        iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic        reg_write, alu_src_a, pc_write, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic        retire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed by the ALU while the instruction is read;
                // IR and PC only load on the ack cycle.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b01;
                ir_write  = bus.mem_ack_i;
                pc_write  = bus.mem_ack_i;
                if (bus.mem_ack_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alu_src_b = 2'b11;
                alu_op    = 2'b01;
                case (bus.Op_i)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EX;
`endif
                    default: begin
                        // Unsupported opcode retires as a nop.
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b01;
                state_d   = (bus.Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ack_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ack_i) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                pc_src    = 2'b01;
                pc_write  = bus.Zero_i;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b01;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: begin
                // Unreachable encodings recover to IDLE with outputs quiet.
                state_d = S_IDLE;
            end
        endcase

        // An instruction retires when control returns to FETCH from any
        // state other than IDLE (start) or FETCH itself (ack wait).
        retire      = (state_d == S_FETCH) && (state_q != S_IDLE) &&
                      (state_q != S_FETCH);
        instr_cnt_d = retire ? instr_cnt_q + 32'd1 : instr_cnt_q;
    end

    assign bus.IorD_o      = iord;
    assign bus.MemRead_o   = mem_read;
    assign bus.MemWrite_o  = mem_write;
    assign bus.IRWrite_o   = ir_write;
    assign bus.RegDst_o    = reg_dst;
    assign bus.MemtoReg_o  = mem_to_reg;
    assign bus.RegWrite_o  = reg_write;
    assign bus.ALUSrcA_o   = alu_src_a;
    assign bus.ALUSrcB_o   = alu_src_b;
    assign bus.ALUOp_o     = alu_op;
    assign bus.PCSrc_o     = pc_src;
    assign bus.PCWrite_o   = pc_write;
    assign bus.illegal_o   = illegal;
    assign bus.state_o     = state_q;
    assign bus.instr_cnt_o = instr_cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Drives multicycle_control through directed and random instruction streams.
//   A responsive memory model acks strobes after a chosen delay; each
//   instruction is summarised (cycle count, strobe cycles, writes, pulses)
//   and compared with values derived from the instruction class and delays.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_J = 4, C_ADDI = 5, C_ILL = 6;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] seq [0:63];
    int         seq_len;
    int         st_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'b000000: return C_R;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
`ifdef MC_ADDI_EN
            6'b001000: return C_ADDI;
`endif
            default:   return C_ILL;
        endcase
    endfunction

    function automatic logic [31:0] ctrl_vec();
        return 32'({bus.IorD_o, bus.MemRead_o, bus.MemWrite_o, bus.IRWrite_o,
                    bus.RegDst_o, bus.MemtoReg_o, bus.RegWrite_o, bus.ALUSrcA_o,
                    bus.ALUSrcB_o, bus.ALUOp_o, bus.PCSrc_o, bus.PCWrite_o,
                    bus.illegal_o});
    endfunction

    // Called at a falling edge with the DUT in FETCH; returns at the falling
    // edge where the next FETCH begins (that cycle is left for the next call).
    task automatic run_instr(input logic [5:0] op, input logic zero, input int dfetch,
                             input int dmem, input string tag);
        int cls, d, wait_cnt, base;
        int mr, mw, iord, irw, pcw, rw, m2r, rdst, ill, br, jmp;
        int exp_cycles, exp_mr, exp_mw, exp_iord, exp_pcw, exp_rw;
        bit is_mem, left_fetch, done;
        logic [31:0] cnt0;

        cls = classify(op);
        mr = 0; mw = 0; iord = 0; irw = 0; pcw = 0; rw = 0;
        m2r = 0; rdst = 0; ill = 0; br = 0; jmp = 0;
        st_cycles = 0; seq_len = 0; wait_cnt = 0;
        left_fetch = 0; done = 0; cnt0 = '0;
        bus.Op_i   = op;
        bus.Zero_i = zero;

        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) begin
                cnt0 = bus.instr_cnt_o;
                check({tag, "_entry_state"}, 32'(bus.state_o), 32'd1);
            end
            if (left_fetch && bus.state_o == 4'd1) begin
                done = 1;
            end else begin
                if (bus.state_o != 4'd1) left_fetch = 1;
                if (bus.MemRead_o || bus.MemWrite_o) begin
                    d = bus.IorD_o ? dmem : dfetch;
                    bus.mem_ack_i = (wait_cnt == d);
                    wait_cnt = (wait_cnt == d) ? 0 : wait_cnt + 1;
                end else begin
                    bus.mem_ack_i = 1'($urandom_range(0, 1));
                end
                bus.start_i = 1'($urandom_range(0, 1));
                #1;
                st_cycles++;
                if (seq_len < 64) begin
                    seq[seq_len] = bus.state_o;
                    seq_len++;
                end
                if (bus.MemRead_o)  mr++;
                if (bus.MemWrite_o) mw++;
                if (bus.IorD_o)     iord++;
                if (bus.IRWrite_o)  irw++;
                if (bus.PCWrite_o)  pcw++;
                if (bus.RegWrite_o) rw++;
                if (bus.RegWrite_o && bus.MemtoReg_o) m2r++;
                if (bus.RegWrite_o && bus.RegDst_o)   rdst++;
                if (bus.illegal_o)  ill++;
                if (bus.PCWrite_o && bus.PCSrc_o == 2'b01) br++;
                if (bus.PCWrite_o && bus.PCSrc_o == 2'b10) jmp++;
            end
        end
        check({tag, "_completed"}, 32'(done), 32'd1);

        // Expected values from the instruction-class latency table.
        case (cls)
            C_LW:                 base = 5;
            C_SW, C_R, C_ADDI:    base = 4;
            C_BEQ, C_J:           base = 3;
            default:              base = 2;
        endcase
        is_mem     = (cls == C_LW) || (cls == C_SW);
        exp_cycles = base + dfetch + (is_mem ? dmem : 0);
        exp_mr     = dfetch + 1 + ((cls == C_LW) ? dmem + 1 : 0);
        exp_mw     = (cls == C_SW) ? dmem + 1 : 0;
        exp_iord   = is_mem ? dmem + 1 : 0;
        exp_pcw    = 1 + (((cls == C_J) || (cls == C_BEQ && zero)) ? 1 : 0);
        exp_rw     = ((cls == C_R) || (cls == C_LW) || (cls == C_ADDI)) ? 1 : 0;

        check({tag, "_cycles"},    st_cycles, exp_cycles);
        check({tag, "_memread"},   mr, exp_mr);
        check({tag, "_memwrite"},  mw, exp_mw);
        check({tag, "_iord"},      iord, exp_iord);
        check({tag, "_irwrite"},   irw, 1);
        check({tag, "_pcwrite"},   pcw, exp_pcw);
        check({tag, "_regwrite"},  rw, exp_rw);
        check({tag, "_memtoreg"},  m2r, (cls == C_LW) ? 1 : 0);
        check({tag, "_regdst"},    rdst, (cls == C_R) ? 1 : 0);
        check({tag, "_illegal"},   ill, (cls == C_ILL) ? 1 : 0);
        check({tag, "_br_target"}, br, (cls == C_BEQ && zero) ? 1 : 0);
        check({tag, "_jmp_target"}, jmp, (cls == C_J) ? 1 : 0);
        check({tag, "_count"},     bus.instr_cnt_o, cnt0 + 32'd1);
        $display("[%0t] %s op=%b zero=%0d dfetch=%0d dmem=%0d cycles=%0d cnt=%0d",
                 $time, tag, op, zero, dfetch, dmem, st_cycles, bus.instr_cnt_o);
    endtask

    logic [5:0] rop;
    bit         found;

    initial begin
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.Op_i      = 6'd0;
        bus.Zero_i    = 1'b0;
        bus.mem_ack_i = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_count", bus.instr_cnt_o, 32'd0);
        check("rst_ctrl",  ctrl_vec(), 32'd0);
        rst = 1'b0;

        // IDLE holds without start.
        repeat (2) @(negedge clk);
        #1;
        check("idle_hold", 32'(bus.state_o), 32'd0);
        bus.start_i = 1'b1;
        check("idle_start_ctrl", ctrl_vec(), 32'd0);
        @(negedge clk);

        // R-type with immediate acks: exact state walk.
        run_instr(6'b000000, 1'b0, 0, 0, "r_first");
        check("r_seq", 32'({seq[0], seq[1], seq[2], seq[3]}), 32'h1278);
        check("r_seq_len", seq_len, 4);

        // lw with the data read acked after three wait cycles.
        run_instr(6'b100011, 1'b0, 0, 3, "lw_wait3");

        // beq taken, then not taken.
        run_instr(6'b000100, 1'b1, 0, 0, "beq_taken");
        run_instr(6'b000100, 1'b0, 1, 0, "beq_not_taken");

        // Illegal opcodes, including addi (legal only when configured in).
        run_instr(6'b111111, 1'b0, 0, 0, "illegal_3f");
        run_instr(6'b001000, 1'b0, 0, 0, "addi");
        run_instr(6'b101011, 1'b0, 2, 1, "sw_wait");
        run_instr(6'b000010, 1'b0, 0, 0, "jump");

        // Random instruction stream.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 6))
                0: rop = 6'b000000;
                1: rop = 6'b100011;
                2: rop = 6'b101011;
                3: rop = 6'b000100;
                4: rop = 6'b000010;
                5: rop = 6'b001000;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), "rand");
        end

        // Reset while MEMWR sees an ack.
        found = 0;
        bus.Op_i = 6'b101011;
        for (int c = 0; c < 16; c++) begin
            if (bus.state_o == 4'd6) begin
                found = 1;
                break;
            end
            bus.mem_ack_i = 1'b1;
            @(negedge clk);
        end
        check("reach_memwr", 32'(found), 32'd1);
        bus.mem_ack_i = 1'b1;
        rst = 1'b1;
        #1;
        check("memwr_strobe_pre_rst", 32'(bus.MemWrite_o), 32'd1);
        @(negedge clk);
        #1;
        check("rst_memwr_state", 32'(bus.state_o), 32'd0);
        check("rst_memwr_write", 32'(bus.MemWrite_o), 32'd0);
        check("rst_memwr_count", bus.instr_cnt_o, 32'd0);
        check("rst_memwr_ctrl",  ctrl_vec(), 32'd0);
        $display("[%0t] reset_in_memwr state=%0d cnt=%0d", $time, bus.state_o, bus.instr_cnt_o);

        // Counter wrap: preload all-ones, then retire a jump.
        rst = 1'b0;
        bus.start_i = 1'b1;
        @(posedge clk);
        #2;
        force dut.instr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt_q;
        #1;
        check("wrap_preload", bus.instr_cnt_o, 32'hFFFF_FFFF);
        @(negedge clk);
        run_instr(6'b000010, 1'b0, 0, 0, "wrap_jump");
        check("wrap_zero", bus.instr_cnt_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, required completion within bound");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath: a Moore/Mealy state machine that walks each instruction through fetch, decode, execute, memory and write-back over 3–5+ cycles. It drives the shared ALU, the unified instruction/data memory port, the IR, the PC and the register file. It stretches memory states until the memory acknowledges, and it counts retired instructions. It sits beside the datapath top level, taking the opcode from the IR and `Zero_i` from the ALU.

## Interface
- No parameters.
- `clk_i  in  1  clock; all state updates on rising edge`
- `rst_i  in  1  synchronous, active-high reset`
- `start_i  in  1  leave IDLE and begin fetching; ignored once running`
- `Op_i  in  6  opcode field IR[31:26]; stable from DECODE until return to FETCH`
- `Zero_i  in  1  ALU zero flag`
- `mem_ack_i  in  1  memory access complete this cycle`
- `IorD_o  out  1  memory address select: 0=PC, 1=ALUOut`
- `MemRead_o / MemWrite_o  out  1  memory strobes, held until ack`
- `IRWrite_o  out  1  load IR`
- `RegDst_o  out  1  0=rt, 1=rd`
- `MemtoReg_o  out  1  0=ALUOut, 1=MDR`
- `RegWrite_o  out  1  register file write`
- `ALUSrcA_o  out  1  0=PC, 1=rs`
- `ALUSrcB_o  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2`
- `ALUOp_o  out  2  00=R-type(funct), 01=add, 10=sub`
- `PCSrc_o  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target`
- `PCWrite_o  out  1  PC load enable`
- `illegal_o  out  1  one-cycle pulse on unsupported opcode`
- `state_o  out  4  current state encoding`
- `instr_cnt_o  out  32  retired-instruction count`

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010; addi 001000 only when configured in.
- Every control output defaults to 0 in any state where it is not listed below.
- Outputs are decoded from the state. PCWrite_o, IRWrite_o and the retire event in FETCH/BRANCH/memory states are additionally gated by inputs, as stated.
- States (encoding: actions → next state):
  - IDLE(0): no outputs → FETCH if start_i, else IDLE.
  - FETCH(1): IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=01, PCSrc=00.
    - IRWrite=PCWrite=mem_ack_i.
    - Stay in FETCH until ack; on ack → DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=01 (branch target into ALUOut). Dispatch on Op_i:
    - lw/sw → MEMADDR; R → EXEC; beq → BRANCH; j → JUMP; addi → ADDI_EX.
    - Any other opcode → FETCH with illegal_o=1 for this cycle. This counts as retired (executes as a nop).
  - MEMADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=01 → MEMRD if lw, MEMWR if sw.
  - MEMRD(4): IorD=1, MemRead=1; stay until ack → MEMWB.
  - MEMWB(5): RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
  - MEMWR(6): IorD=1, MemWrite=1; stay until ack → FETCH.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=00 → RWB.
  - RWB(8): RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=10, PCSrc=01, PCWrite=Zero_i → FETCH.
  - JUMP(10): PCSrc=10, PCWrite=1 → FETCH.
  - ADDI_EX(11): ALUSrcA=1, ALUSrcB=10, ALUOp=01 → ADDI_WB.
  - ADDI_WB(12): RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
  - Encodings 13–15: unreachable; any such state → IDLE next cycle with all outputs 0.
- Retire: instr_cnt_o increments by 1 on every transition into FETCH from a non-IDLE state. It is 32-bit modulo and wraps 0xFFFFFFFF→0.

## Timing
- Reset (rst_i high at an edge): state=IDLE, instr_cnt_o=0, all outputs 0. Reset wins over every other event, including mid-access with a pending ack.
- Zero-wait memory (ack in the first cycle of the access): lw 5 cycles; sw, R, addi 4; beq, j 3. Each ack-wait cycle adds 1 cycle.
- Memory strobes stay asserted and IorD stays stable every cycle until the ack cycle inclusive. They deassert the cycle after the ack.
- mem_ack_i is ignored outside FETCH, MEMRD and MEMWR.
- illegal_o is high exactly one cycle, concurrent with DECODE.

## Configuration
- `MC_ADDI_EN` defined: addi is decoded and states 11/12 exist.
- Undefined: opcode 001000 takes the illegal path (illegal_o pulse, nop, counted); states 11/12 are unreachable.

## Test plan
- Reset, then start_i=1 for 1 cycle, ack always 1, R-type → states 0,1,2,7,8,1; RegWrite=1 only in RWB; instr_cnt_o=1.
- lw with ack delayed 3 cycles in MEMRD → MemRead=IorD=1 for 4 cycles; MEMWB follows; total 8 cycles; MemtoReg=1 in MEMWB.
- beq with Zero_i=1, then again with Zero_i=0 → PCWrite=1/PCSrc=01 in BRANCH only when Zero_i=1; both retire (count +2).
- Opcode 111111 → illegal_o pulses once in DECODE; next state FETCH; count +1. Repeat with 001000 with and without MC_ADDI_EN.
- rst_i asserted in MEMWR while ack=1 → next cycle IDLE, MemWrite=0, instr_cnt_o=0.
- Preload counter path to 0xFFFFFFFF (run via force), retire j → instr_cnt_o=0.
